// File: rtl/inst_arbiter.sv
// inst_arbiter: five-source (core0-3, ethernet) instruction arbiter feeding a
// small output FIFO toward the decoder.
// Optional feature macro: INST_ARB_ETH_PRIORITY_EN -- ethernet gets strict
// priority and the cores round-robin among themselves.
module inst_arbiter #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] core0_inst,
  input  logic [DATA_WIDTH-1:0] core1_inst,
  input  logic [DATA_WIDTH-1:0] core2_inst,
  input  logic [DATA_WIDTH-1:0] core3_inst,
  input  logic [DATA_WIDTH-1:0] ethernet_inst,
  input  logic [4:0]            src_valid,
  output logic [4:0]            src_ready,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [2:0]            inst_src,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned PTR_W = CNT_W - 1;
`ifdef INST_ARB_ETH_PRIORITY_EN
  localparam int unsigned RR_W  = 2;
`else
  localparam int unsigned RR_W  = 3;
`endif

  // FIFO storage (no reset needed) and control state
  logic [DATA_WIDTH-1:0] r_mem     [FIFO_DEPTH];
  logic [2:0]            r_src_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [RR_W-1:0]       r_rr_ptr;
  logic [15:0]           r_drop_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_grant_any;
  logic [2:0]            w_grant_idx;
  logic                  w_push;
  logic                  w_pop;
  logic [RR_W-1:0]       w_rr_next;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Grant selection: first valid source at or after rr_ptr
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 3'd0;
`ifdef INST_ARB_ETH_PRIORITY_EN
    if (src_valid[4]) begin
      w_grant_any = 1'b1;
      w_grant_idx = 3'd4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [1:0] cand;
        cand = r_rr_ptr + 2'(k);
        if (!w_grant_any && src_valid[cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = {1'b0, cand};
        end
      end
    end
`else
    for (int k = 0; k < 5; k++) begin
      logic [3:0] sum;
      sum = 4'(r_rr_ptr) + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      if (!w_grant_any && src_valid[sum[2:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = sum[2:0];
      end
    end
`endif
  end

  // Round-robin pointer successor of the current grant
  always_comb begin
`ifdef INST_ARB_ETH_PRIORITY_EN
    w_rr_next = w_grant_idx[1:0] + 2'd1;
`else
    w_rr_next = (w_grant_idx == 3'd4) ? 3'd0 : w_grant_idx + 3'd1;
`endif
  end

  // Accept only when not full; held low while in reset
  assign src_ready = (rst_n && !w_full && w_grant_any) ? (5'b00001 << w_grant_idx) : 5'b00000;
  assign w_push    = |src_ready;
  assign w_pop     = !w_empty && inst_ready;

  // Payload mux for the granted source
  always_comb begin
    w_push_data = core0_inst;
    case (w_grant_idx)
      3'd1:    w_push_data = core1_inst;
      3'd2:    w_push_data = core2_inst;
      3'd3:    w_push_data = core3_inst;
      3'd4:    w_push_data = ethernet_inst;
      default: w_push_data = core0_inst;
    endcase
  end

  // FIFO data write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]     <= w_push_data;
      r_src_mem[r_wr_ptr] <= w_grant_idx;
    end
  end

  // Pointers, occupancy, round-robin state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
`ifdef INST_ARB_ETH_PRIORITY_EN
      if (w_push && (w_grant_idx != 3'd4)) r_rr_ptr <= w_rr_next;
`else
      if (w_push) r_rr_ptr <= w_rr_next;
`endif
    end
  end

  // Saturating count of cycles with a pending source against a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_full && (|src_valid) && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign inst_out   = r_mem[r_rd_ptr];
  assign inst_src   = r_src_mem[r_rd_ptr];
  assign inst_valid = !w_empty;
  assign fifo_count = r_count;
  assign drop_cnt   = r_drop_cnt;

endmodule
